mult_issue_queue: RTL and testbench

- Upstream stage of `multiplier`. Buffers operand pairs (x, y) in a small FIFO.
- Issues one pair at a time to the multiplier: drives x/y and pulses `start`, then waits for `ready` and captures `product`.
- Presents each result on a valid/ready output port, with a timeout watchdog.
- Serialises multiplier use, so the multi-cycle multiplier can be fed back-to-back from a streaming source.

---
 rtl/mult_issue_queue_pkg.sv | 22 ++
 rtl/mult_issue_queue_if.sv | 38 +++
 rtl/mult_issue_queue_sync_fifo.sv | 64 ++++++
 rtl/mult_issue_queue.sv | 169 ++++++++++++++++
 tb/tb_mult_issue_queue.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_issue_queue_pkg.sv
// Shared types and default sizing for the multiplier issue queue.
// The FSM state enum lives here so the top and any debug tooling agree on its encoding.
package mult_pkg;

  localparam int DEF_W       = 4;
  localparam int DEF_PW      = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } issue_state_t;

  // Bits needed to hold every value from 0 up to max_value inclusive
  function automatic int count_bits(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/mult_issue_queue_if.sv
// Operand, multiplier and result signals of the issue queue, bundled as one interface.
// The slave modport is the issue queue itself; master is whatever surrounds it.
interface mult_issue_queue_if #(
  parameter int W  = mult_pkg::DEF_W,
  parameter int PW = mult_pkg::DEF_PW
);

  logic          op_valid;
  logic [W-1:0]  op_x;
  logic [W-1:0]  op_y;
  logic          op_ready;

  logic [W-1:0]  mult_x;
  logic [W-1:0]  mult_y;
  logic          mult_start;
  logic          mult_ready;
  logic [PW-1:0] mult_product;

  logic          res_valid;
  logic [PW-1:0] res_product;
  logic          res_ready;

  logic          timeout_err;
  logic          busy;

  modport master (
    output op_valid, op_x, op_y, mult_ready, mult_product, res_ready,
    input  op_ready, mult_x, mult_y, mult_start, res_valid, res_product,
           timeout_err, busy
  );

  modport slave (
    input  op_valid, op_x, op_y, mult_ready, mult_product, res_ready,
    output op_ready, mult_x, mult_y, mult_start, res_valid, res_product,
           timeout_err, busy
  );

endinterface

// File: rtl/mult_issue_queue_sync_fifo.sv
// Small synchronous FIFO holding packed operand pairs ahead of the multiplier.
// Occupancy is counted separately from the pointers so full and empty are unambiguous.
module sync_fifo
  import mult_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = count_bits(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still safe when the head leaves on the same edge
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/mult_issue_queue.sv
// Issue queue in front of a multi-cycle multiplier: buffers operand pairs, issues one at a time,
// waits for the multiplier with a watchdog and offers each product on a valid/ready port.
module mult_issue_queue
  import mult_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int PW      = DEF_PW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic              clk_in,
  input logic              rst_in,
  mult_issue_queue_if.slave io
);

  localparam int CW = count_bits(TIMEOUT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  issue_state_t state_q;
  issue_state_t state_d;

  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic [2*W-1:0] fifo_dout;

  logic [W-1:0]   x_q;
  logic [W-1:0]   y_q;
  logic [PW-1:0]  product_q;
  logic           res_valid_q;
  logic           timeout_q;
  logic           armed_q;
  logic [CW-1:0]  wait_cnt_q;

  logic           start_o;
  logic           busy_o;
  logic           complete;
  logic           expire;

  sync_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    ({io.op_x, io.op_y}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // op_ready depends on occupancy only, never on op_valid
  assign fifo_push = io.op_valid && !fifo_full;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (complete) begin
          state_d = RESULT;
        end else if (expire) begin
          state_d = IDLE;
        end
      end
      RESULT: begin
        if (io.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completion needs a low ready seen earlier in this WAIT, so a ready level left high
  // by the previous operation is never mistaken for this one finishing.
  always_comb begin
    start_o  = 1'b0;
    busy_o   = 1'b1;
    fifo_pop = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o   = 1'b0;
        fifo_pop = !fifo_empty;
      end
      ISSUE: begin
        start_o = 1'b1;
      end
      WAIT: begin
        complete = armed_q && io.mult_ready;
        expire   = !complete && (wait_cnt_q == LAST_WAIT);
      end
      RESULT: begin
        busy_o = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q         <= '0;
      y_q         <= '0;
      product_q   <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      armed_q     <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      if (fifo_pop) begin
        {x_q, y_q} <= fifo_dout;
      end
      if (state_q == ISSUE) begin
        armed_q    <= 1'b0;
        wait_cnt_q <= '0;
      end
      if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + CW'(1);
        if (!io.mult_ready) begin
          armed_q <= 1'b1;
        end
      end
      if (complete) begin
        product_q   <= io.mult_product;
        res_valid_q <= 1'b1;
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end
      if ((state_q == RESULT) && io.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign io.op_ready    = !fifo_full;
  assign io.mult_x      = x_q;
  assign io.mult_y      = y_q;
  assign io.mult_start  = start_o;
  assign io.res_valid   = res_valid_q;
  assign io.res_product = product_q;
  assign io.timeout_err = timeout_q;
  assign io.busy        = busy_o;

endmodule

// File: tb/tb_mult_issue_queue.sv
// Bench for mult_issue_queue: behavioural multiplier, scoreboard of x*y products in push order,
// table-driven burst, hand-written corner sequences and a randomized traffic phase.
module tb_mult_issue_queue;
  import mult_pkg::*;

  localparam int W       = DEF_W;
  localparam int PW      = DEF_PW;
  localparam int DEPTH   = DEF_DEPTH;
  localparam int TIMEOUT = DEF_TIMEOUT;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  mult_issue_queue_if #(.W(W), .PW(PW)) bus ();

  mult_issue_queue #(
    .W       (W),
    .PW      (PW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .io     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check_output(input string name, input logic [31:0] got,
                                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h required=0x%0h", name, got, exp);
    end
  endfunction

  function automatic void fail_event(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got=no event required=event", name);
  endfunction

  // Behavioural multiplier: ready drops on start and returns after a latency, product
  // shows a junk value until then. The op whose index equals hang_at never completes.
  int            fixed_lat    = 4;
  int            hang_at      = -1;
  int            model_starts = 0;
  int            rem          = 0;
  logic [PW-1:0] pend         = '0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      bus.mult_ready   <= 1'b1;
      bus.mult_product <= PW'(8'hEE);
      rem              <= 0;
    end else if (bus.mult_start) begin
      bus.mult_ready   <= 1'b0;
      bus.mult_product <= PW'(8'hEE);
      pend             <= PW'(bus.mult_x) * PW'(bus.mult_y);
      if (model_starts == hang_at) rem <= 0;
      else if (fixed_lat != 0)     rem <= fixed_lat;
      else                         rem <= $urandom_range(1, 5);
      model_starts <= model_starts + 1;
    end else if (rem == 1) begin
      bus.mult_ready   <= 1'b1;
      bus.mult_product <= pend;
      rem              <= 0;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end
  end

  // Reference model: every accepted pair must be issued in order and yield x*y in order
  logic [2*W-1:0] exp_ops [$];
  logic [PW-1:0]  exp_res [$];
  logic [PW-1:0]  got_res [$];
  int             start_cnt = 0;
  logic           prev_busy = 1'b0;
  logic           prev_hold = 1'b0;
  logic           prev_to   = 1'b0;
  logic [PW-1:0]  prev_prod = '0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      exp_ops.delete();
      exp_res.delete();
      prev_busy = 1'b0;
      prev_hold = 1'b0;
      prev_to   = 1'b0;
    end else begin
      if (bus.mult_start) begin
        start_cnt++;
        check_output("start_only_after_idle", prev_busy, 1'b0);
        if (exp_ops.size() == 0) fail_event("issue_matches_queued_op");
        else check_output("issue_operands", {bus.mult_x, bus.mult_y}, exp_ops.pop_front());
      end
      if (prev_hold) begin
        check_output("res_valid_held", bus.res_valid, 1'b1);
        check_output("res_product_held", bus.res_product, prev_prod);
      end
      if (bus.res_valid && bus.res_ready) begin
        got_res.push_back(bus.res_product);
        if (exp_res.size() == 0) fail_event("result_matches_queued_op");
        else check_output("result_product", bus.res_product, exp_res.pop_front());
      end
      if (bus.timeout_err && !prev_to && exp_res.size() > 0) begin
        void'(exp_res.pop_front());
      end
      if (bus.op_valid && bus.op_ready) begin
        exp_ops.push_back({bus.op_x, bus.op_y});
        exp_res.push_back(PW'(bus.op_x) * PW'(bus.op_y));
      end
      prev_busy = bus.busy;
      prev_hold = bus.res_valid && !bus.res_ready;
      prev_prod = bus.res_product;
      prev_to   = bus.timeout_err;
    end
  end

  typedef struct {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [PW-1:0] prod;
    logic          rdy_after;
  } vec_t;

  vec_t tbl [4];

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
  endtask

  task automatic push_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    bus.op_valid = 1'b1;
    bus.op_x     = x;
    bus.op_y     = y;
    @(negedge clk_in);
    while (!bus.op_ready && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    if (!bus.op_ready) fail_event("push_accepted");
    @(posedge clk_in);
    #1 bus.op_valid = 1'b0;
  endtask

  task automatic wait_res_valid(input string name);
    int n = 0;
    while (!bus.res_valid && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    if (!bus.res_valid) fail_event(name);
  endtask

  task automatic wait_got(input int total, input string name);
    int n = 0;
    while (got_res.size() < total && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (got_res.size() < total) fail_event(name);
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_in);
    while (bus.busy && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (bus.busy) fail_event("return_to_idle");
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < 4; i++) begin
      push_op(tbl[i].x, tbl[i].y);
      check_output($sformatf("op_ready_after_push%0d", i), bus.op_ready, tbl[i].rdy_after);
      check_output($sformatf("res_valid_during_push%0d", i), bus.res_valid, 1'b1);
    end
  endtask

  task automatic measure_timeout();
    int n   = 0;
    int cyc = 0;
    logic saw_valid = 1'b0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!bus.mult_start && n < 20);
    if (!bus.mult_start) fail_event("timeout_op_issued");
    do begin
      @(negedge clk_in);
      cyc++;
      if (bus.res_valid) saw_valid = 1'b1;
    end while (!bus.timeout_err && cyc < 40);
    check_output("timeout_cycles", cyc, TIMEOUT + 1);
    check_output("no_result_on_timeout", saw_valid, 1'b0);
  endtask

  task automatic watch_wait_state();
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!bus.mult_start && n < 20);
    if (!bus.mult_start) fail_event("reset_op_issued");
    repeat (2) @(negedge clk_in);
    check_output("busy_in_wait", bus.busy, 1'b1);
  endtask

  initial begin
    int   base;
    int   s0;
    logic seen_valid;
    logic drv_done;

    bus.op_valid  = 1'b0;
    bus.op_x      = '0;
    bus.op_y      = '0;
    bus.res_ready = 1'b0;

    tbl[0] = '{x: 4'd1, y: 4'd2, prod: 8'd2,  rdy_after: 1'b1};
    tbl[1] = '{x: 4'd3, y: 4'd4, prod: 8'd12, rdy_after: 1'b1};
    tbl[2] = '{x: 4'd5, y: 4'd6, prod: 8'd30, rdy_after: 1'b1};
    tbl[3] = '{x: 4'd7, y: 4'd8, prod: 8'd56, rdy_after: 1'b0};

    do_reset();
    @(negedge clk_in);
    check_output("reset_op_ready", bus.op_ready, 1'b1);
    check_output("reset_busy", bus.busy, 1'b0);
    check_output("reset_res_valid", bus.res_valid, 1'b0);
    check_output("reset_mult_start", bus.mult_start, 1'b0);
    check_output("reset_timeout_err", bus.timeout_err, 1'b0);
    check_output("reset_data", {bus.mult_x, bus.mult_y, bus.res_product}, 32'd0);
    @(posedge clk_in);
    #1;

    // 11*3 against a multiplier whose ready idles high with a junk product
    fixed_lat = 4;
    base = got_res.size();
    push_op(4'b1011, 4'b0011);
    wait_res_valid("first_result_valid");
    check_output("first_product", bus.res_product, 8'd33);
    check_output("single_start_pulse", start_cnt, 1);
    @(posedge clk_in);
    #1;
    apply_stimulus();
    check_output("no_start_while_result_held", start_cnt, 1);
    bus.res_ready = 1'b1;
    wait_got(base + 5, "burst_results");
    if (got_res.size() >= base + 5) begin
      check_output("burst_first", got_res[base], 8'd33);
      for (int i = 0; i < 4; i++) begin
        check_output($sformatf("burst_order%0d", i), got_res[base + 1 + i], tbl[i].prod);
      end
    end
    check_output("burst_start_count", start_cnt, 5);

    // Result held by the consumer for six cycles
    wait_idle();
    bus.res_ready = 1'b0;
    base = got_res.size();
    push_op(4'd9, 4'd9);
    wait_res_valid("hold_result_valid");
    repeat (6) begin
      @(negedge clk_in);
      check_output("hold_valid", bus.res_valid, 1'b1);
      check_output("hold_product", bus.res_product, 8'd81);
    end
    @(posedge clk_in);
    #1 bus.res_ready = 1'b1;
    wait_got(base + 1, "hold_result_taken");

    // Random traffic with random latency and random consumer back-pressure
    fixed_lat = 0;
    base = got_res.size();
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk_in);
            #1;
          end
          push_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk_in);
          #1 bus.res_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.res_ready = 1'b1;
    wait_got(base + 40, "random_results");
    check_output("random_scoreboard_drained", exp_res.size(), 0);

    // Watchdog: first op hangs, the op queued behind it still completes
    wait_idle();
    fixed_lat = 3;
    hang_at = model_starts;
    base = got_res.size();
    fork
      begin
        push_op(4'd2, 4'd3);
        push_op(4'd4, 4'd5);
      end
      measure_timeout();
    join
    wait_got(base + 1, "after_timeout_result");
    if (got_res.size() >= base + 1) check_output("after_timeout_product", got_res[base], 8'd20);
    check_output("timeout_sticky", bus.timeout_err, 1'b1);

    // Reset while an op waits on the multiplier with more queued
    wait_idle();
    fixed_lat = 5;
    fork
      begin
        push_op(4'd1, 4'd1);
        push_op(4'd2, 4'd2);
        push_op(4'd3, 4'd3);
      end
      watch_wait_state();
    join
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    check_output("midreset_busy", bus.busy, 1'b0);
    check_output("midreset_op_ready", bus.op_ready, 1'b1);
    check_output("midreset_res_valid", bus.res_valid, 1'b0);
    check_output("midreset_timeout_cleared", bus.timeout_err, 1'b0);
    s0 = start_cnt;
    seen_valid = 1'b0;
    repeat (15) begin
      @(negedge clk_in);
      if (bus.res_valid) seen_valid = 1'b1;
    end
    check_output("midreset_no_result", seen_valid, 1'b0);
    check_output("midreset_no_issue", start_cnt, s0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
